mult_issue_capture: RTL

//  Sequential issue/capture stage wrapped around the combinational 32x32 Booth/Wallace/Kogge-Stone multiplier.

---
 rtl/mult_issue_capture.sv | 106 ++++++++++
 1 files changed

// File: rtl/mult_issue_capture.sv
// Issue/capture stage for the combinational 32x32 multiplier: holds operands for a
// multi-cycle path, captures Product, checks it against the DSP reference and returns it.
module mult_issue_capture #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned ERR_CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [31:0]          req_a,
    input  logic [31:0]          req_b,
    input  logic                 req_sign,
    output logic [31:0]          mul_a,
    output logic [31:0]          mul_b,
    output logic                 mul_sign,
    input  logic [63:0]          mul_product,
    input  logic [63:0]          mul_product_dsp,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [63:0]          rsp_product,
    output logic                 rsp_mismatch,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HOLD = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [7:0] CNT_INIT = 8'(WAIT_CYCLES - 1);

    logic [1:0]           r_state;
    logic [7:0]           r_cnt;
    logic [31:0]          r_mul_a;
    logic [31:0]          r_mul_b;
    logic                 r_mul_sign;
    logic [63:0]          r_rsp_product;
    logic                 r_rsp_mismatch;
    logic [ERR_CNT_W-1:0] r_err_count;

    logic [63:0]          w_corr_a;
    logic [63:0]          w_corr_b;
    logic [63:0]          w_expected;
    logic                 w_mismatch;

    // The DSP product is always unsigned; signed results subtract the sign-bit cross terms.
    always_comb begin
        w_corr_a   = r_mul_a[31] ? {r_mul_b, 32'h0} : '0;
        w_corr_b   = r_mul_b[31] ? {r_mul_a, 32'h0} : '0;
        w_expected = r_mul_sign ? (mul_product_dsp - w_corr_a - w_corr_b) : mul_product_dsp;
        w_mismatch = (mul_product != w_expected);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_mul_a        <= '0;
            r_mul_b        <= '0;
            r_mul_sign     <= 1'b0;
            r_rsp_product  <= '0;
            r_rsp_mismatch <= 1'b0;
            r_err_count    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_mul_a    <= req_a;
                        r_mul_b    <= req_b;
                        r_mul_sign <= req_sign;
                        r_cnt      <= CNT_INIT;
                        r_state    <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (r_cnt != 8'd0) begin
                        r_cnt <= r_cnt - 8'd1;
                    end else begin
                        r_rsp_product  <= mul_product;
                        r_rsp_mismatch <= w_mismatch;
                        if (w_mismatch && (r_err_count != '1))
                            r_err_count <= r_err_count + 1'b1;
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready    = (r_state == S_IDLE);
    assign busy         = (r_state != S_IDLE);
    assign rsp_valid    = (r_state == S_RESP);
    assign mul_a        = r_mul_a;
    assign mul_b        = r_mul_b;
    assign mul_sign     = r_mul_sign;
    assign rsp_product  = r_rsp_product;
    assign rsp_mismatch = r_rsp_mismatch;
    assign err_count    = r_err_count;

endmodule
